aig_seq_eval: RTL and testbench

AIG_SEQ_EVAL -- requirements
Module: aig_seq_eval

---
 rtl/aig_seq_eval.sv | 174 +++++++++++++++++
 tb/tb_aig_seq_eval.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aig_seq_eval.sv
// rtl/aig_seq_eval.sv - sequential and-inverter-graph evaluator with a programmable node table
module aig_seq_eval #(
  parameter int NUM_IN    = 4,
  parameter int MAX_NODES = 16,
  localparam int LIT_W  = $clog2(1 + NUM_IN + MAX_NODES) + 1,
  localparam int ADDR_W = $clog2(MAX_NODES),
  localparam int CNT_W  = $clog2(MAX_NODES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LIT_W-1:0]  cfg_lit_a,
  input  logic [LIT_W-1:0]  cfg_lit_b,
  input  logic [CNT_W-1:0]  cfg_num_nodes,
  input  logic [LIT_W-1:0]  cfg_out_lit,
  output logic              cfg_ready,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NUM_IN-1:0] x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              y,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     k_q, k_d, num_q, num_d, k_inc;
  logic [LIT_W-1:0]     out_lit_q, out_lit_d;
  logic [NUM_IN-1:0]    x_q, x_d;
  logic [MAX_NODES-1:0] node_val_q, node_val_d;
  logic [LIT_W-1:0]     tbl_a_q [MAX_NODES];
  logic [LIT_W-1:0]     tbl_a_d [MAX_NODES];
  logic [LIT_W-1:0]     tbl_b_q [MAX_NODES];
  logic [LIT_W-1:0]     tbl_b_d [MAX_NODES];
  logic                 err_q, err_d, y_q, y_d, out_valid_q, out_valid_d, idle_q, idle_d;
  logic [LIT_W-1:0]     cur_a, cur_b;
  logic [1:0]           res_a, res_b, res_y;

  // Returns {bad, value}; a literal pointing at a node at or beyond limit reads as 0 and flags bad.
  function automatic logic [1:0] resolve_lit(input logic [LIT_W-1:0] lit,
                                             input logic [NUM_IN-1:0] xv,
                                             input logic [MAX_NODES-1:0] nv,
                                             input int limit);
    int   idx;
    logic v;
    logic bad;
    idx = int'(lit[LIT_W-1:1]);
    v   = 1'b0;
    bad = 1'b0;
    if (idx == 0) begin
      v = 1'b0;
    end else if (idx <= NUM_IN) begin
      for (int i = 0; i < NUM_IN; i++) if (i == idx - 1) v = xv[i];
    end else if (idx - NUM_IN - 1 < limit) begin
      for (int i = 0; i < MAX_NODES; i++) if (i == idx - NUM_IN - 1) v = nv[i];
    end else begin
      bad = 1'b1;
    end
    return {bad, bad ? 1'b0 : (v ^ lit[0])};
  endfunction

  always_comb begin
    cur_a = '0;
    cur_b = '0;
    for (int i = 0; i < MAX_NODES; i++) begin
      if (i == int'(k_q)) begin
        cur_a = tbl_a_q[i];
        cur_b = tbl_b_q[i];
      end
    end
  end

  assign res_a = resolve_lit(cur_a, x_q, node_val_q, int'(k_q));
  assign res_b = resolve_lit(cur_b, x_q, node_val_q, int'(k_q));
  assign res_y = resolve_lit(out_lit_q, x_q, node_val_q, int'(num_q));
  assign k_inc = k_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    num_d       = num_q;
    out_lit_d   = out_lit_q;
    x_d         = x_q;
    node_val_d  = node_val_q;
    tbl_a_d     = tbl_a_q;
    tbl_b_d     = tbl_b_q;
    err_d       = err_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (cfg_we) begin
          tbl_a_d[cfg_addr] = cfg_lit_a;
          tbl_b_d[cfg_addr] = cfg_lit_b;
        end
        if (in_valid) begin
          x_d       = x;
          out_lit_d = cfg_out_lit;
          k_d       = '0;
          state_d   = EVAL;
          if (cfg_num_nodes > CNT_W'(MAX_NODES)) begin
            num_d = CNT_W'(MAX_NODES);
            err_d = 1'b1;
          end else begin
            num_d = cfg_num_nodes;
            err_d = 1'b0;
          end
        end
      end
      EVAL: begin
        if (k_q < num_q) begin
          for (int i = 0; i < MAX_NODES; i++)
            if (i == int'(k_q)) node_val_d[i] = res_a[0] & res_b[0];
          err_d = err_q | res_a[1] | res_b[1];
        end
        k_d = k_inc;
        if (k_inc >= num_q) state_d = DONE;
      end
      DONE: begin
        // First DONE cycle registers the output literal; the result is then held for the consumer.
        if (!out_valid_q) begin
          y_d         = res_y[0];
          err_d       = err_q | res_y[1];
          out_valid_d = 1'b1;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    idle_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      num_q       <= '0;
      out_lit_q   <= '0;
      x_q         <= '0;
      node_val_q  <= '0;
      tbl_a_q     <= '{default: '0};
      tbl_b_q     <= '{default: '0};
      err_q       <= 1'b0;
      y_q         <= 1'b0;
      out_valid_q <= 1'b0;
      idle_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      num_q       <= num_d;
      out_lit_q   <= out_lit_d;
      x_q         <= x_d;
      node_val_q  <= node_val_d;
      tbl_a_q     <= tbl_a_d;
      tbl_b_q     <= tbl_b_d;
      err_q       <= err_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
      idle_q      <= idle_d;
    end
  end

  assign in_ready  = idle_q;
  assign cfg_ready = idle_q;
  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign err       = err_q;

endmodule

// File: tb/tb_aig_seq_eval.sv
// tb/tb_aig_seq_eval.sv - self-checking bench for aig_seq_eval (default and 6-input/32-node builds)
module tb_aig_seq_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       cfg_we, cfg_ready, in_valid, in_ready, out_valid, out_ready, y, err;
  logic [3:0] cfg_addr, x;
  logic [5:0] cfg_lit_a, cfg_lit_b, cfg_out_lit;
  logic [4:0] cfg_num_nodes;

  logic       d1_cfg_we, d1_cfg_ready, d1_in_valid, d1_in_ready, d1_out_valid, d1_out_ready, d1_y, d1_err;
  logic [4:0] d1_cfg_addr;
  logic [6:0] d1_cfg_lit_a, d1_cfg_lit_b, d1_cfg_out_lit;
  logic [5:0] d1_cfg_num_nodes, d1_x;

  aig_seq_eval dut0 (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_lit_a(cfg_lit_a),
    .cfg_lit_b(cfg_lit_b), .cfg_num_nodes(cfg_num_nodes), .cfg_out_lit(cfg_out_lit),
    .cfg_ready(cfg_ready), .in_valid(in_valid), .in_ready(in_ready), .x(x),
    .out_valid(out_valid), .out_ready(out_ready), .y(y), .err(err)
  );

  aig_seq_eval #(.NUM_IN(6), .MAX_NODES(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .cfg_we(d1_cfg_we), .cfg_addr(d1_cfg_addr), .cfg_lit_a(d1_cfg_lit_a),
    .cfg_lit_b(d1_cfg_lit_b), .cfg_num_nodes(d1_cfg_num_nodes), .cfg_out_lit(d1_cfg_out_lit),
    .cfg_ready(d1_cfg_ready), .in_valid(d1_in_valid), .in_ready(d1_in_ready), .x(d1_x),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .y(d1_y), .err(d1_err)
  );

  int total = 0;
  int bad   = 0;
  int sh_a [16];
  int sh_b [16];
  bit mv [32];

  typedef struct {int n; int ol; int xv; int ey; int ee; int lat;} vec_t;
  vec_t vt [23];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Value of a literal for the default build; nodes below limit are readable.
  task automatic opnd(input int lit, input int limit, input int xv, output int v, output int b);
    int idx, c;
    idx = lit >> 1;
    c   = lit & 1;
    v   = 0;
    b   = 0;
    if (idx == 0) v = c;
    else if (idx <= 4) v = ((xv >> (idx - 1)) & 1) ^ c;
    else if (idx - 5 < limit) v = int'(mv[idx - 5]) ^ c;
    else b = 1;
  endtask

  task automatic model(input int n, input int ol, input int xv, output int ey, output int ee);
    int nn, va, vb, ba, bb;
    nn = (n > 16) ? 16 : n;
    ee = (n > 16) ? 1 : 0;
    for (int k = 0; k < nn; k++) begin
      opnd(sh_a[k], k, xv, va, ba);
      opnd(sh_b[k], k, xv, vb, bb);
      mv[k] = ((va & vb) != 0);
      if (ba != 0 || bb != 0) ee = 1;
    end
    opnd(ol, nn, xv, va, ba);
    ey = (ba != 0) ? 0 : va;
    if (ba != 0) ee = 1;
  endtask

  task automatic wr(input int a, input int la, input int lb);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = 4'(a); cfg_lit_a = 6'(la); cfg_lit_b = 6'(lb);
    @(negedge clk);
    cfg_we = 1'b0;
    sh_a[a] = la;
    sh_b[a] = lb;
  endtask

  task automatic job(input string nm, input int n, input int ol, input int xv, input int wa,
                     input int la, input int lb, input int ey, input int ee, input int elat);
    int cnt;
    @(negedge clk);
    check({nm, " in_ready"}, int'(in_ready), 1);
    in_valid = 1'b1; x = 4'(xv); cfg_num_nodes = 5'(n); cfg_out_lit = 6'(ol);
    if (wa >= 0) begin
      cfg_we = 1'b1; cfg_addr = 4'(wa); cfg_lit_a = 6'(la); cfg_lit_b = 6'(lb);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (out_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, " latency"}, cnt, elat);
    check({nm, " y"}, int'(y), ey);
    check({nm, " err"}, int'(err), ee);
  endtask

  task automatic mjob(input string nm, input int n, input int ol, input int xv,
                      input int wa, input int la, input int lb);
    int ey, ee, nn;
    if (wa >= 0) begin
      sh_a[wa] = la;
      sh_b[wa] = lb;
    end
    model(n, ol, xv, ey, ee);
    nn = (n > 16) ? 16 : n;
    job(nm, n, ol, xv, wa, la, lb, ey, ee, ((nn > 1) ? nn : 1) + 1);
  endtask

  task automatic prog_xor();
    wr(0, 2, 5);
    wr(1, 3, 4);
    wr(2, 11, 13);
  endtask

  task automatic prog_chain();
    wr(0, 2, 4);
    for (int k = 1; k < 16; k++) wr(k, 2 * (4 + k), 2 * ((k % 4) + 1));
  endtask

  task automatic d1_job(input string nm, input int xv, input int ey);
    int cnt;
    @(negedge clk);
    d1_in_valid = 1'b1; d1_x = 6'(xv); d1_cfg_num_nodes = 6'd32; d1_cfg_out_lit = 7'd76;
    @(posedge clk);
    #1;
    d1_in_valid = 1'b0;
    cnt = 0;
    @(negedge clk);
    while (d1_out_valid !== 1'b1 && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, " latency"}, cnt, 33);
    check({nm, " y"}, int'(d1_y), ey);
    check({nm, " err"}, int'(d1_err), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int seen, ey, xr;
    rst_n = 1'b1;
    cfg_we = 0; cfg_addr = 0; cfg_lit_a = 0; cfg_lit_b = 0; cfg_num_nodes = 0; cfg_out_lit = 0;
    in_valid = 0; x = 0; out_ready = 1;
    d1_cfg_we = 0; d1_cfg_addr = 0; d1_cfg_lit_a = 0; d1_cfg_lit_b = 0; d1_cfg_num_nodes = 0;
    d1_cfg_out_lit = 0; d1_in_valid = 0; d1_x = 0; d1_out_ready = 1;
    for (int i = 0; i < 16; i++) begin sh_a[i] = 0; sh_b[i] = 0; end

    for (int i = 0; i < 16; i++) vt[i] = '{3, 15, i, (i ^ (i >> 1)) & 1, 0, 4};
    vt[16] = '{0, 3, 0, 1, 0, 2};
    vt[17] = '{0, 1, 0, 1, 0, 2};
    vt[18] = '{0, 2, 1, 1, 0, 2};
    vt[19] = '{0, 0, 5, 0, 0, 2};
    vt[20] = '{0, 10, 0, 0, 1, 2};
    vt[21] = '{20, 15, 1, 1, 1, 17};
    vt[22] = '{3, 14, 3, 1, 0, 4};

    #2 rst_n = 1'b0;
    #1;
    check("reset out_valid", int'(out_valid), 0);
    check("reset y", int'(y), 0);
    check("reset err", int'(err), 0);
    check("reset in_ready", int'(in_ready), 1);
    check("reset cfg_ready", int'(cfg_ready), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    prog_xor();
    for (int i = 0; i < 23; i++)
      job($sformatf("vec%0d", i), vt[i].n, vt[i].ol, vt[i].xv, -1, 0, 0, vt[i].ey, vt[i].ee, vt[i].lat);

    // Write and acceptance in the same cycle: node 2 becomes plain x0.
    mjob("same_cycle", 3, 14, 1, 2, 2, 2);
    check("same_cycle y_is_x0", int'(y), 1);

    prog_xor();
    out_ready = 1'b0;
    mjob("bp", 3, 15, 1, -1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        cfg_we = 1'b1; cfg_addr = 4'd2; cfg_lit_a = 6'd0; cfg_lit_b = 6'd0;
      end else begin
        cfg_we = 1'b0;
      end
      @(negedge clk);
      check("bp out_valid", int'(out_valid), 1);
      check("bp y", int'(y), 1);
      check("bp in_ready", int'(in_ready), 0);
      check("bp cfg_ready", int'(cfg_ready), 0);
    end
    cfg_we = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp release out_valid", int'(out_valid), 0);
    check("bp release in_ready", int'(in_ready), 1);
    mjob("bp write_ignored", 3, 15, 0, -1, 0, 0);

    wr(0, 10, 2);
    mjob("malformed self_ref", 1, 10, 1, -1, 0, 0);
    check("malformed self_ref err_set", int'(err), 1);
    mjob("malformed out_lit", 1, 40, 1, -1, 0, 0);
    mjob("err_clears", 0, 2, 1, -1, 0, 0);

    prog_chain();
    @(negedge clk);
    in_valid = 1'b1; x = 4'hF; cfg_num_nodes = 5'd16; cfg_out_lit = 6'd40;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset out_valid", int'(out_valid), 0);
    check("midreset in_ready", int'(in_ready), 1);
    check("midreset cfg_ready", int'(cfg_ready), 1);
    check("midreset err", int'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin sh_a[i] = 0; sh_b[i] = 0; end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    check("midreset no_result", seen, 0);
    mjob("midreset table_zeroed", 1, 10, 15, -1, 0, 0);
    prog_chain();
    mjob("chain all_ones", 16, 40, 15, -1, 0, 0);
    check("chain all_ones y", int'(y), 1);
    mjob("chain x7", 16, 40, 7, -1, 0, 0);

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) wr($urandom_range(0, 15), $urandom_range(0, 63), $urandom_range(0, 63));
      mjob($sformatf("rand%0d", it), $urandom_range(0, 20), $urandom_range(0, 63),
           $urandom_range(0, 15), -1, 0, 0);
    end

    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      d1_cfg_we = 1'b1; d1_cfg_addr = 5'(k);
      d1_cfg_lit_a = (k == 0) ? 7'd2 : 7'(2 * (6 + k));
      d1_cfg_lit_b = (k == 0) ? 7'd4 : 7'(2 * ((k % 6) + 1));
    end
    @(negedge clk);
    d1_cfg_we = 1'b0;
    d1_job("big all_ones", 6'h3F, 1);
    for (int b = 0; b < 6; b += 2) begin
      xr = 6'h3F ^ (1 << b);
      ey = 0;
      d1_job($sformatf("big clear_bit%0d", b), xr, ey);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
